// File: rtl/fib_bcd.sv
// fib_bcd: sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// Accepts one W-bit value through in_valid/in_ready, produces three decimal
// digits held behind out_valid/out_ready.
// Optional: define FIB_BCD_SEG_EN to add registered seven-segment outputs
// (seg_h/seg_t/seg_o, active-high, bit order gfedcba).
module fib_bcd #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [3:0]   bcd_h,
  output logic [3:0]   bcd_t,
  output logic [3:0]   bcd_o,
  output logic         out_valid,
  input  logic         out_ready
`ifdef FIB_BCD_SEG_EN
  ,
  output logic [6:0]   seg_h,
  output logic [6:0]   seg_t,
  output logic [6:0]   seg_o
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [W-1:0]  bin;
  logic [11:0]   bcd;
  logic [3:0]    cnt;

  logic [11:0]   adj;
  logic [11+W:0] sh;
  logic [11:0]   bcd_nxt;
  logic [W-1:0]  bin_nxt;
  logic          last;

  // Add-3 correction per nibble; 4-bit adds, no carry between nibbles.
  for (genvar i = 0; i < 3; i++) begin : g_adj
    assign adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                   : bcd[4*i +: 4];
  end

  assign sh      = {adj, bin} << 1;
  assign bcd_nxt = sh[11+W:W];
  assign bin_nxt = sh[W-1:0];
  assign last    = (cnt == 4'(W - 1));

  // Ready is a pure state decode so upstream sees no input-to-output path.
  assign in_ready = (state == IDLE);

`ifdef FIB_BCD_SEG_EN
  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0: seg_dec = 7'h3F;
      4'd1: seg_dec = 7'h06;
      4'd2: seg_dec = 7'h5B;
      4'd3: seg_dec = 7'h4F;
      4'd4: seg_dec = 7'h66;
      4'd5: seg_dec = 7'h6D;
      4'd6: seg_dec = 7'h7D;
      4'd7: seg_dec = 7'h07;
      4'd8: seg_dec = 7'h7F;
      4'd9: seg_dec = 7'h6F;
      default: seg_dec = 7'h00;
    endcase
  endfunction

  // Segment registers track the digit registers, updating on the DONE entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_h <= 7'h3F;
      seg_t <= 7'h3F;
      seg_o <= 7'h3F;
    end else if (state == SHIFT && last) begin
      seg_h <= seg_dec(bcd_nxt[11:8]);
      seg_t <= seg_dec(bcd_nxt[7:4]);
      seg_o <= seg_dec(bcd_nxt[3:0]);
    end
  end
`endif

  // Control FSM with shift engine; digits only change when entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      bcd_h     <= '0;
      bcd_t     <= '0;
      bcd_o     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          bin   <= in_data;
          bcd   <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd <= bcd_nxt;
          bin <= bin_nxt;
          cnt <= cnt + 4'd1;
          if (last) begin
            bcd_h     <= bcd_nxt[11:8];
            bcd_t     <= bcd_nxt[7:4];
            bcd_o     <= bcd_nxt[3:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
